// File: rtl/lsu_pkg.sv
// Shared constants and state type for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] CAUSE_NONE     = 2'd0;
   localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
   localparam logic [1:0] CAUSE_FAULT    = 2'd2;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      CAPTURE,
      RESP
   } lsu_state_e;

endpackage

// File: rtl/lsu_req_check.sv
// Combinational legality check of a request: illegal width beats access fault.
module lsu_req_check
   import lsu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 8
) (
   input  logic            we,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] ea,
   output logic [1:0]      cause
);

   logic illegal;
   logic fault;

   // classify width code and address range, then apply precedence
   always_comb begin
      if (we) illegal = !(funct3 inside {F3_B, F3_H, F3_W});
      else    illegal = funct3 inside {3'b011, 3'b110, 3'b111};
      fault = |ea[XLEN-1:ADDR_W];
      cause = CAUSE_NONE;
      if (illegal)    cause = CAUSE_ILLEGAL;
      else if (fault) cause = CAUSE_FAULT;
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, runs the memory bus handshake and
// returns a single-cycle response with load data or an exception cause.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a request; legality checked at accept
//   ACCESS  | memory enabled; store data on the bus, write commits at edge
//   CAPTURE | load only; registered memory read sampled at end of cycle
//   RESP    | resp_valid pulse, memory idle
module load_store_unit
   import lsu_pkg::*;
#(
   parameter  int SIZE   = 5,
   parameter  int XLEN   = 32,
   localparam int ADDR_W = SIZE + 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_base,
   input  logic [XLEN-1:0]   req_offset,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [4:0]        req_rd,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_data,
   output logic [4:0]        resp_rd,
   output logic [1:0]        resp_cause,
   output logic [XLEN-1:0]   resp_badaddr,
   inout  wire  [31:0]       mem_data,
   output logic              mem_wr_rd,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_size,
   input  logic              mem_exception
);

   lsu_state_e      state_q, state_d;
   logic            we_q, we_d;
   logic [2:0]      f3_q, f3_d;
   logic [XLEN-1:0] ea_q, ea_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [4:0]      rd_q, rd_d;
   logic [1:0]      cause_q, cause_d;
   logic [XLEN-1:0] data_q, data_d;

   logic [XLEN-1:0] ea;
   logic [1:0]      chk_cause;

   assign ea = req_base + req_offset;

   lsu_req_check #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_req_check (
      .we     (req_we),
      .funct3 (req_funct3),
      .ea     (ea),
      .cause  (chk_cause)
   );

   // state and request registers, synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         ea_q    <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         cause_q <= CAUSE_NONE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         ea_q    <= ea_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         cause_q <= cause_d;
         data_q  <= data_d;
      end
   end

   // next-state and request latching
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      ea_d    = ea_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      cause_d = cause_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               ea_d    = ea;
               wdata_d = req_wdata;
               rd_d    = req_rd;
               cause_d = chk_cause;
               data_d  = '0;
               state_d = (chk_cause != CAUSE_NONE) ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            if (mem_exception) begin
               cause_d = CAUSE_MISALIGN;
               state_d = RESP;
            end else if (we_q) begin
               state_d = RESP;
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            data_d  = XLEN'(mem_data);
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs decoded from state; everything reads zero outside its window
   always_comb begin
      req_ready    = (state_q == IDLE);
      resp_valid   = (state_q == RESP);
      resp_data    = (resp_valid && cause_q == CAUSE_NONE) ? data_q : '0;
      resp_rd      = resp_valid ? rd_q : '0;
      resp_cause   = resp_valid ? cause_q : CAUSE_NONE;
      resp_badaddr = (resp_valid && cause_q != CAUSE_NONE) ? ea_q : '0;
      mem_en       = (state_q == ACCESS) || (state_q == CAPTURE);
      mem_wr_rd    = (state_q == ACCESS) && we_q;
      mem_addr     = mem_en ? ea_q[ADDR_W-1:0] : '0;
      mem_size     = mem_en ? f3_q : '0;
   end

   // bus is driven only while a store is in ACCESS
   assign mem_data = mem_wr_rd ? wdata_q[31:0] : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
   localparam int SIZE   = 5;
   localparam int XLEN   = 32;
   localparam int ADDR_W = SIZE + 3;
   localparam int MBYTES = 1 << ADDR_W;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [2:0]        req_funct3 = '0;
   logic [XLEN-1:0]   req_base = '0;
   logic [XLEN-1:0]   req_offset = '0;
   logic [XLEN-1:0]   req_wdata = '0;
   logic [4:0]        req_rd = '0;
   logic              resp_valid;
   logic [XLEN-1:0]   resp_data;
   logic [4:0]        resp_rd;
   logic [1:0]        resp_cause;
   logic [XLEN-1:0]   resp_badaddr;
   wire  [31:0]       mem_data;
   logic              mem_wr_rd;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [2:0]        mem_size;
   logic              mem_exception;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   load_store_unit #(.SIZE(SIZE), .XLEN(XLEN)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
      .resp_cause(resp_cause), .resp_badaddr(resp_badaddr),
      .mem_data(mem_data), .mem_wr_rd(mem_wr_rd), .mem_en(mem_en),
      .mem_addr(mem_addr), .mem_size(mem_size), .mem_exception(mem_exception)
   );

   // ---------------- data memory environment ----------------
   logic [7:0]  mem [0:MBYTES-1];
   logic [31:0] mem_rd_q  = '0;
   logic        mem_drv_q = 1'b0;

   function automatic logic misal(input logic [2:0] sz, input logic [ADDR_W-1:0] a);
      case (sz[1:0])
         2'b01:   misal = a[0];
         2'b10:   misal = |a[1:0];
         default: misal = 1'b0;
      endcase
   endfunction

   assign mem_exception = mem_en && misal(mem_size, mem_addr);

   always @(posedge CLK) begin
      mem_drv_q <= mem_en && !mem_wr_rd && !mem_exception;
      if (mem_en && !mem_exception) begin
         if (mem_wr_rd) begin
            mem[mem_addr] <= mem_data[7:0];
            if (mem_size[1:0] != 2'b00) mem[mem_addr + 1] <= mem_data[15:8];
            if (mem_size[1:0] == 2'b10) begin
               mem[mem_addr + 2] <= mem_data[23:16];
               mem[mem_addr + 3] <= mem_data[31:24];
            end
         end else begin
            case (mem_size)
               3'b000:  mem_rd_q <= {{24{mem[mem_addr][7]}}, mem[mem_addr]};
               3'b001:  mem_rd_q <= {{16{mem[mem_addr+1][7]}}, mem[mem_addr+1], mem[mem_addr]};
               3'b100:  mem_rd_q <= {24'h0, mem[mem_addr]};
               3'b101:  mem_rd_q <= {16'h0, mem[mem_addr+1], mem[mem_addr]};
               default: mem_rd_q <= {mem[mem_addr+3], mem[mem_addr+2], mem[mem_addr+1], mem[mem_addr]};
            endcase
         end
      end
   end

   assign mem_data = mem_drv_q ? mem_rd_q : 32'hzzzz_zzzz;

   // ---------------- reference model ----------------
   logic [7:0] ref_mem [0:MBYTES-1];

   task automatic ref_apply(input logic we, input logic [2:0] f3, input logic [31:0] ea,
                            input logic [31:0] wd, output logic [31:0] d,
                            output logic [1:0] c, output int lat);
      int nb;
      logic [31:0] v;
      d = '0; c = 2'd0; lat = 0;
      nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) begin
         c = 2'd3; lat = 1;
      end else if (ea >= MBYTES) begin
         c = 2'd2; lat = 1;
      end else if (ea % nb != 0) begin
         c = 2'd1; lat = 2;
      end else if (we) begin
         for (int i = 0; i < nb; i++) ref_mem[ea + i] = wd[8*i +: 8];
         lat = 2;
      end else begin
         v = '0;
         for (int i = 0; i < nb; i++) v = v + (32'(ref_mem[ea + i]) << (8 * i));
         if (!f3[2] && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
         d = v; lat = 3;
      end
   endtask

   // ---------------- driver ----------------
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                         output int lat, output logic [31:0] data, output logic [1:0] cause,
                         output logic [31:0] bad, output logic [4:0] rd_o,
                         output logic en_seen, output logic bus_ok, output logic pulse_ok);
      int w;
      lat = 0; data = '0; cause = '0; bad = '0; rd_o = '0;
      en_seen = 1'b0; bus_ok = 1'b1; pulse_ok = 1'b1;
      @(negedge CLK);
      w = 0;
      while (!req_ready && w < 20) begin @(negedge CLK); w++; end
      req_valid = 1'b1; req_we = we; req_funct3 = f3;
      req_base = base; req_offset = off; req_wdata = wd; req_rd = rd;
      @(negedge CLK);
      req_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (c > 1) @(negedge CLK);
         if (mem_en) en_seen = 1'b1;
         if (mem_en && mem_wr_rd && mem_data !== wd) bus_ok = 1'b0;
         if (resp_valid) begin
            lat = c; data = resp_data; cause = resp_cause;
            bad = resp_badaddr; rd_o = resp_rd;
            break;
         end
      end
      @(negedge CLK);
      if (resp_valid) pulse_ok = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      tests++;
      if ({req_ready, resp_valid, mem_en, mem_wr_rd} !== 4'b1000) begin
         fails++;
         $display("FAIL reset_ctrl: ready/valid/en/wr got %b want 1000",
                  {req_ready, resp_valid, mem_en, mem_wr_rd});
      end
      tests++;
      if (resp_data !== '0 || resp_rd !== '0 || resp_cause !== '0 || resp_badaddr !== '0 ||
          mem_addr !== '0 || mem_size !== '0) begin
         fails++;
         $display("FAIL reset_vals: data %h rd %h cause %h bad %h addr %h size %h want all 0",
                  resp_data, resp_rd, resp_cause, resp_badaddr, mem_addr, mem_size);
      end
      RST = 1'b0;
   endtask

   task automatic check_resp(input string name, input int lat, input logic [31:0] d,
                             input logic [1:0] c, input logic [31:0] b, input logic [4:0] r,
                             input int elat, input logic [31:0] ed, input logic [1:0] ec,
                             input logic [31:0] eb, input logic [4:0] er);
      tests++;
      if (lat !== elat || d !== ed || c !== ec || b !== eb || r !== er) begin
         fails++;
         $display("FAIL %s: lat %0d data %h cause %0d bad %h rd %0d, want lat %0d data %h cause %0d bad %h rd %0d",
                  name, lat, d, c, b, r, elat, ed, ec, eb, er);
      end
   endtask

   task automatic test_loads();
      int lat; logic [31:0] d, b; logic [1:0] c; logic [4:0] r; logic en, bus, pl;
      do_req(0, 3'b000, 32'h10, 32'h0, 32'h0, 5'd1, lat, d, c, b, r, en, bus, pl);
      check_resp("lb_0x10", lat, d, c, b, r, 3, 32'hFFFF_FFF1, 2'd0, 32'h0, 5'd1);
      tests++;
      if (pl !== 1'b1) begin fails++; $display("FAIL resp_pulse: second-cycle valid got %b want 0", !pl); end
      do_req(0, 3'b101, 32'h20, 32'hFFFF_FFF2, 32'h0, 5'd2, lat, d, c, b, r, en, bus, pl);
      check_resp("lhu_0x12", lat, d, c, b, r, 3, 32'h0000_8040, 2'd0, 32'h0, 5'd2);
      do_req(0, 3'b100, 32'h11, 32'h0, 32'h0, 5'd3, lat, d, c, b, r, en, bus, pl);
      check_resp("lbu_0x11", lat, d, c, b, r, 3, 32'h0000_0020, 2'd0, 32'h0, 5'd3);
   endtask

   task automatic test_store();
      int lat, el; logic [31:0] d, b, ed; logic [1:0] c, ec; logic [4:0] r; logic en, bus, pl;
      ref_apply(1, 3'b000, 32'h13, 32'h0000_00AB, ed, ec, el);
      do_req(1, 3'b000, 32'h13, 32'h0, 32'h0000_00AB, 5'd4, lat, d, c, b, r, en, bus, pl);
      check_resp("sb_0x13", lat, d, c, b, r, 2, 32'h0, 2'd0, 32'h0, 5'd4);
      tests++;
      if (bus !== 1'b1 || en !== 1'b1) begin
         fails++; $display("FAIL sb_bus: bus_ok %b en %b want 1 1", bus, en);
      end
      do_req(0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd5, lat, d, c, b, r, en, bus, pl);
      check_resp("lw_after_sb", lat, d, c, b, r, 3, 32'hAB40_20F1, 2'd0, 32'h0, 5'd5);
   endtask

   task automatic test_misalign();
      int lat; logic [31:0] d, b; logic [1:0] c; logic [4:0] r; logic en, bus, pl;
      do_req(0, 3'b010, 32'h12, 32'h0, 32'h0, 5'd6, lat, d, c, b, r, en, bus, pl);
      check_resp("lw_misalign", lat, d, c, b, r, 2, 32'h0, 2'd1, 32'h12, 5'd6);
      do_req(1, 3'b010, 32'h11, 32'h0, 32'h1234_5678, 5'd7, lat, d, c, b, r, en, bus, pl);
      check_resp("sw_misalign", lat, d, c, b, r, 2, 32'h0, 2'd1, 32'h11, 5'd7);
      do_req(0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd8, lat, d, c, b, r, en, bus, pl);
      check_resp("lw_unchanged", lat, d, c, b, r, 3, 32'hAB40_20F1, 2'd0, 32'h0, 5'd8);
   endtask

   task automatic test_fault_illegal();
      int lat; logic [31:0] d, b; logic [1:0] c; logic [4:0] r; logic en, bus, pl;
      do_req(1, 3'b010, 32'h400, 32'h0, 32'hDEAD_BEEF, 5'd9, lat, d, c, b, r, en, bus, pl);
      check_resp("sw_fault", lat, d, c, b, r, 1, 32'h0, 2'd2, 32'h400, 5'd9);
      tests++;
      if (en !== 1'b0) begin fails++; $display("FAIL fault_mem_en: seen %b want 0", en); end
      do_req(1, 3'b100, 32'h10, 32'h0, 32'hDEAD_BEEF, 5'd10, lat, d, c, b, r, en, bus, pl);
      check_resp("sb_illegal", lat, d, c, b, r, 1, 32'h0, 2'd3, 32'h10, 5'd10);
      tests++;
      if (en !== 1'b0) begin fails++; $display("FAIL illegal_mem_en: seen %b want 0", en); end
      do_req(0, 3'b111, 32'h400, 32'h0, 32'h0, 5'd11, lat, d, c, b, r, en, bus, pl);
      check_resp("ld_illegal_over_fault", lat, d, c, b, r, 1, 32'h0, 2'd3, 32'h400, 5'd11);
   endtask

   task automatic test_reset_capture();
      logic seen;
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
      req_base = 32'h10; req_offset = '0; req_rd = 5'd12;
      @(negedge CLK); req_valid = 1'b0;   // ACCESS
      @(negedge CLK);                     // CAPTURE
      tests++;
      if (mem_en !== 1'b1 || mem_wr_rd !== 1'b0) begin
         fails++; $display("FAIL capture_bus: en %b wr %b want 1 0", mem_en, mem_wr_rd);
      end
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      tests++;
      if (req_ready !== 1'b1 || mem_en !== 1'b0 || resp_valid !== 1'b0) begin
         fails++; $display("FAIL rst_capture: ready %b en %b valid %b want 1 0 0",
                           req_ready, mem_en, resp_valid);
      end
      seen = 1'b0;
      repeat (4) begin @(negedge CLK); if (resp_valid) seen = 1'b1; end
      tests++;
      if (seen !== 1'b0) begin fails++; $display("FAIL rst_no_resp: response seen %b want 0", seen); end
   endtask

   task automatic test_back_to_back();
      int n, cyc [2]; logic [4:0] rds [2]; logic [31:0] ds [2]; logic [1:0] cs [2];
      logic [31:0] e0, e1; logic [1:0] c0, c1; int l0, l1; logic prev_rdy;
      int lat; logic [31:0] d, b; logic [1:0] c; logic [4:0] r; logic en, bus, pl;
      ref_apply(0, 3'b010, 32'h10, 32'h0, e0, c0, l0);
      ref_apply(1, 3'b010, 32'h20, 32'hCAFE_F00D, e1, c1, l1);
      n = 0;
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
      req_base = 32'h10; req_offset = '0; req_rd = 5'd13;
      @(negedge CLK);
      req_we = 1'b1; req_base = 32'h18; req_offset = 32'h8;
      req_wdata = 32'hCAFE_F00D; req_rd = 5'd14;
      prev_rdy = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (k > 1) @(negedge CLK);
         if (prev_rdy) req_valid = 1'b0;
         if (req_valid && req_ready) prev_rdy = 1'b1;
         if (resp_valid && n < 2) begin
            cyc[n] = k; rds[n] = resp_rd; ds[n] = resp_data; cs[n] = resp_cause; n++;
         end
      end
      req_valid = 1'b0;
      tests++;
      if (n != 2) begin
         fails++; $display("FAIL b2b_count: responses %0d want 2", n);
      end else begin
         check_resp("b2b_load", cyc[0], ds[0], cs[0], 32'h0, rds[0], l0, e0, c0, 32'h0, 5'd13);
         check_resp("b2b_store", cyc[1], ds[1], cs[1], 32'h0, rds[1], 4 + l1, e1, c1, 32'h0, 5'd14);
      end
      do_req(0, 3'b010, 32'h20, 32'h0, 32'h0, 5'd15, lat, d, c, b, r, en, bus, pl);
      check_resp("b2b_readback", lat, d, c, b, r, 3, 32'hCAFE_F00D, 2'd0, 32'h0, 5'd15);
   endtask

   task automatic test_random();
      int lat, el; logic [31:0] d, b, ed, base, off, ea, wd; logic [1:0] c, ec; logic [4:0] r, rd;
      logic en, bus, pl, we; logic [2:0] f3;
      for (int i = 0; i < 150; i++) begin
         we   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         base = $urandom_range(0, MBYTES - 1);
         off  = 32'($urandom_range(0, 31)) - 32'd16;
         if ($urandom_range(0, 15) == 0) base = $urandom;
         wd   = $urandom;
         rd   = 5'($urandom);
         ea   = base + off;
         ref_apply(we, f3, ea, wd, ed, ec, el);
         do_req(we, f3, base, off, wd, rd, lat, d, c, b, r, en, bus, pl);
         check_resp("random", lat, d, c, b, r, el, ed, ec, (ec != 0) ? ea : 32'h0, rd);
         tests++;
         if (en !== (ec == 2'd0 || ec == 2'd1) || bus !== 1'b1 || pl !== 1'b1) begin
            fails++;
            $display("FAIL random_bus: en %b bus_ok %b pulse_ok %b want %b 1 1 (we %b f3 %0d ea %h)",
                     en, bus, pl, (ec == 2'd0 || ec == 2'd1), we, f3, ea);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < MBYTES; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[16] = 8'hF1; mem[17] = 8'h20; mem[18] = 8'h40; mem[19] = 8'h80;
      for (int i = 16; i < 20; i++) ref_mem[i] = mem[i];
      test_reset();
      test_loads();
      test_store();
      test_misalign();
      test_fault_illegal();
      test_reset_capture();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the CPU execute stage and the byte-addressable data memory, which has a one-cycle registered read, a shared tristate data bus and a size/misalignment exception output.
Accepts one load or store request per handshake and computes the effective address (base + offset).
Sequences the memory bus protocol, captures load data, checks legality and returns a one-cycle response with the result or an exception cause.
Keeps the execute stage free of tristate and memory-timing concerns.

Parameters:
SIZE, 5, memory depth exponent; memory byte-address width is ADDR_W = SIZE+3.
XLEN, 32, data and address width of the request side.

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (IDLE only)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RISC-V width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_base  in  XLEN  rs1 value
req_offset  in  XLEN  sign-extended immediate
req_wdata  in  XLEN  store data (rs2)
req_rd  in  5  destination register tag, echoed on the response
resp_valid  out  1  one-cycle response pulse
resp_data  out  XLEN  load result; 0 for stores and exceptions
resp_rd  out  5  echoed tag
resp_cause  out  2  0 none, 1 misaligned, 2 access fault, 3 illegal width
resp_badaddr  out  XLEN  effective address when resp_cause!=0, else 0
mem_data  inout  32  memory data bus
mem_wr_rd  out  1  1=write
mem_en  out  1  memory enable
mem_addr  out  ADDR_W  byte address
mem_size  out  3  funct3 forwarded to memory
mem_exception  in  1  memory misalignment flag (combinational)

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_data=0, resp_rd=0, resp_cause=0, resp_badaddr=0, mem_en=0, mem_wr_rd=0, mem_addr=0, mem_size=0, mem_data released (Z). State returns to IDLE.
- FSM states and transitions:
  - IDLE: on req_valid&&req_ready, latch the request, effective address ea = base+offset (mod 2^32) and the legality result. Next state is ACCESS, or RESP directly if illegal or faulted.
  - Illegal width (cause 3): store funct3 not in {000,001,010}, or load funct3 in {011,110,111}.
  - Access fault (cause 2): ea[31:ADDR_W] != 0.
  - Precedence: illegal width beats access fault, which beats misaligned.
  - ACCESS: drive mem_en=1, mem_addr=ea[ADDR_W-1:0], mem_size=funct3, mem_wr_rd=we.
    - If mem_exception=1: cause 1, next RESP. Memory suppresses the write itself.
    - Else store: next RESP. The write commits at this edge.
    - Else load: next CAPTURE.
  - CAPTURE (load only): hold mem_en=1, mem_wr_rd=0, addr/size unchanged. Sample mem_data into resp_data at the end of the cycle; next RESP.
  - RESP: resp_valid=1 for exactly one cycle, mem_en=0; next IDLE. req_ready=0 in every state except IDLE.
- Latency, counting the accept edge as edge 0, resp_valid is high in cycle:
  - load: cycle 3
  - store: cycle 2
  - misaligned: cycle 2
  - illegal/fault: cycle 1
- Memory is never enabled for illegal or faulted requests.
- Tristate rule: mem_data is driven with wdata only when state==ACCESS && we; Z otherwise. The unit never drives the bus during a load, so there is no contention.
- Load extension is performed by memory; the unit passes captured data unmodified.
- No backpressure on the response: the consumer must accept the resp_valid pulse.
- Reset mid-operation: RST wins over all transitions. A store whose ACCESS cycle coincides with the RST edge still commits, because memory has no reset. A load in CAPTURE is discarded with no response.
- A req_valid held during RESP is accepted in the following IDLE cycle.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - cause codes (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_FAULT, CAUSE_ILLEGAL)
  - state enum (IDLE, ACCESS, CAPTURE, RESP)
- Sub-module lsu_req_check: combinational width-legality and access-fault check on (we, funct3, ea). Instantiated once in IDLE.

Test Plan:
- Sign-extended byte load: memory word at 0x10 = 0x804020F1; lb with base=0x10, offset=0 -> resp_data=0xFFFFFFF1, cause 0, resp_valid in cycle 3.
- Unsigned halfword load: same word, lhu with base=0x20, offset=-0x0E (ea=0x12) -> resp_data=0x00008040. Unsigned byte load at 0x11 -> 0x00000020.
- Byte store then read-back: sb 0x000000AB at 0x13, then lw 0x10 -> 0xAB4020F1. Store resp_valid in cycle 2; mem_data Z outside ACCESS.
- Misaligned word load: lw ea=0x12 -> cause 1, badaddr 0x12, resp_data 0. A subsequent lw 0x10 shows the memory contents unchanged.
- Access fault: SIZE=5, sw ea=0x400 -> cause 2 in cycle 1, mem_en never asserted.
- Illegal width: store funct3 100 -> cause 3 in cycle 1, mem_en never asserted.
- Reset during CAPTURE: RST asserted -> no response, req_ready=1 on the next cycle, mem_en=0.
- Back-to-back: after a load response, a second request is accepted without any dropped response.
